icache_refill_queue: RTL and testbench

ICACHE_REFILL_QUEUE -- requirements
Module: icache_refill_queue

---
 rtl/wt_cache_pkg.sv | 34 +++
 rtl/icache_refill_queue_if.sv | 49 ++++
 rtl/fifo_v3.sv | 54 +++++
 rtl/icache_refill_queue.sv | 104 ++++++++++
 tb/tb_icache_refill_queue.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wt_cache_pkg.sv
// Shared types and constants for the write-through icache refill path.
package wt_cache_pkg;

  // Physical address width, AXI id width and cache line width of the core.
  localparam int unsigned PLEN              = 56;
  localparam int unsigned IdWidth           = 4;
  localparam int unsigned ICACHE_LINE_WIDTH = 256;

  // One queued refill request from the icache miss path.
  typedef struct packed {
    logic [PLEN-1:0]    paddr;
    logic               nc;
    logic [IdWidth-1:0] tid;
  } icache_refill_req_t;

  // One in-flight AXI read; killed marks a return that must be swallowed.
  typedef struct packed {
    logic [IdWidth-1:0] tid;
    logic               nc;
    logic               killed;
  } icache_refill_trk_t;

  // Non-cacheable requests go out at their exact address; cacheable ones
  // are aligned down to the start of their line.
  function automatic logic [63:0] refill_addr(input logic [PLEN-1:0] paddr,
                                              input logic            nc,
                                              input int unsigned     line_bytes);
    logic [63:0] addr;
    addr = 64'(paddr);
    if (!nc) addr = addr & ~(64'(line_bytes) - 64'd1);
    return addr;
  endfunction

endpackage

// File: rtl/icache_refill_queue_if.sv
// Refill request, AXI-shim read and completion signals of the refill queue.
interface icache_refill_queue_if
  import wt_cache_pkg::*;
#(
  parameter int unsigned LineWords = ICACHE_LINE_WIDTH / 64
);

  // Miss-path request handshake and payload.
  logic                         req_valid_i;
  logic                         req_ready_o;
  logic [PLEN-1:0]              req_paddr_i;
  logic                         req_nc_i;
  logic [IdWidth-1:0]           req_tid_i;

  // Read request towards the AXI shim.
  logic                         rd_req_o;
  logic                         rd_gnt_i;
  logic [63:0]                  rd_addr_o;
  logic [$clog2(LineWords)-1:0] rd_blen_o;
  logic [IdWidth-1:0]           rd_id_o;

  // Read beat status from the AXI shim.
  logic                         rd_valid_i;
  logic                         rd_last_i;
  logic                         rd_exokay_i;

  // Completion back to the icache.
  logic                         rtrn_valid_o;
  logic [IdWidth-1:0]           rtrn_tid_o;
  logic                         rtrn_nc_o;
  logic                         rtrn_err_o;

  // The refill queue itself.
  modport slave (
    input  req_valid_i, req_paddr_i, req_nc_i, req_tid_i,
           rd_gnt_i, rd_valid_i, rd_last_i, rd_exokay_i,
    output req_ready_o, rd_req_o, rd_addr_o, rd_blen_o, rd_id_o,
           rtrn_valid_o, rtrn_tid_o, rtrn_nc_o, rtrn_err_o
  );

  // Whatever drives requests and models the AXI shim.
  modport master (
    output req_valid_i, req_paddr_i, req_nc_i, req_tid_i,
           rd_gnt_i, rd_valid_i, rd_last_i, rd_exokay_i,
    input  req_ready_o, rd_req_o, rd_addr_o, rd_blen_o, rd_id_o,
           rtrn_valid_o, rtrn_tid_o, rtrn_nc_o, rtrn_err_o
  );

endinterface

// File: rtl/fifo_v3.sv
// Plain synchronous FIFO, no fall-through; push when full / pop when empty are ignored.
module fifo_v3 #(
  parameter int unsigned DEPTH = 4,
  parameter type         dtype = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  dtype            mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == (PtrW + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy bookkeeping; flush drops everything at once.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
    end
  end

  // Storage write.
  // NOTE: storage has no reset; a slot is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/icache_refill_queue.sv
// Queues icache refill requests, issues them as AXI reads and tracks returns in order.
module icache_refill_queue
  import wt_cache_pkg::*;
#(
  parameter int unsigned Depth          = 4,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned LineWords      = ICACHE_LINE_WIDTH / 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  icache_refill_queue_if.slave        bus,
  output logic                        busy_o
);

  localparam int unsigned BlenW     = $clog2(LineWords);
  localparam int unsigned LineBytes = LineWords * 8;
  localparam int unsigned TrkPtrW   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW      = $clog2(MaxOutstanding + 1);

  icache_refill_req_t push_entry, head;
  icache_refill_trk_t trk_q [MaxOutstanding];
  icache_refill_trk_t trk_head;
  logic [TrkPtrW-1:0] trk_wptr_q, trk_rptr_q;
  logic [CntW-1:0]    out_cnt_q;
  logic               err_acc_q;
  logic               q_full, q_empty;
  logic               push, grant, complete, beat_err, emit;

  function automatic logic [TrkPtrW-1:0] trk_next(input logic [TrkPtrW-1:0] p);
    return (p == TrkPtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // Request side: no bypass, and anything arriving during a flush is dropped.
  assign push_entry      = '{paddr: bus.req_paddr_i, nc: bus.req_nc_i, tid: bus.req_tid_i};
  assign bus.req_ready_o = !q_full;
  assign push            = bus.req_valid_i && !q_full && !flush_i;

  // Issue side: the head stays put until granted and the count only grows on
  // a grant, so the request and its payload are stable until rd_gnt_i.
  assign bus.rd_req_o  = !q_empty && (out_cnt_q < CntW'(MaxOutstanding)) && !flush_i;
  assign grant         = bus.rd_req_o && bus.rd_gnt_i;
  assign bus.rd_addr_o = refill_addr(head.paddr, head.nc, LineBytes);
  assign bus.rd_blen_o = head.nc ? '0 : BlenW'(LineWords - 1);
  assign bus.rd_id_o   = head.tid;

  // Return side: beats with nothing outstanding (e.g. after a reset) are ignored.
  assign trk_head = trk_q[trk_rptr_q];
  assign complete = bus.rd_valid_i && bus.rd_last_i && (out_cnt_q != '0);
  assign beat_err = bus.rd_valid_i && !bus.rd_exokay_i && (out_cnt_q != '0);
  assign emit     = complete && !trk_head.killed && !flush_i;

  assign busy_o = !q_empty || (out_cnt_q != '0);

  fifo_v3 #(
    .DEPTH (Depth),
    .dtype (icache_refill_req_t)
  ) i_req_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .full_o  (q_full),
    .empty_o (q_empty),
    .data_i  (push_entry),
    .push_i  (push),
    .data_o  (head),
    .pop_i   (grant)
  );

  // Tracker storage: record each granted read; a flush kills everything in flight.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MaxOutstanding; i++) begin
      if (flush_i) trk_q[i].killed <= 1'b1;
    end
    if (grant) trk_q[trk_wptr_q] <= '{tid: head.tid, nc: head.nc, killed: 1'b0};
  end

  // Tracker pointers, outstanding count, sticky error and registered completion.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trk_wptr_q        <= '0;
      trk_rptr_q        <= '0;
      out_cnt_q         <= '0;
      err_acc_q         <= 1'b0;
      bus.rtrn_valid_o  <= 1'b0;
      bus.rtrn_tid_o    <= '0;
      bus.rtrn_nc_o     <= 1'b0;
      bus.rtrn_err_o    <= 1'b0;
    end else begin
      if (grant)    trk_wptr_q <= trk_next(trk_wptr_q);
      if (complete) trk_rptr_q <= trk_next(trk_rptr_q);
      out_cnt_q <= out_cnt_q + CntW'(grant) - CntW'(complete);
      if (complete)      err_acc_q <= 1'b0;
      else if (beat_err) err_acc_q <= 1'b1;
      bus.rtrn_valid_o <= emit;
      bus.rtrn_err_o   <= emit && (err_acc_q || beat_err);
      if (emit) begin
        bus.rtrn_tid_o <= trk_head.tid;
        bus.rtrn_nc_o  <= trk_head.nc;
      end
    end
  end

endmodule

// File: tb/tb_icache_refill_queue.sv
// Directed bench for icache_refill_queue: default instance plus a 3-deep-outstanding one.
module tb_icache_refill_queue;
  import wt_cache_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  logic flush_i, flush3;
  logic busy_o, busy3;
  int   total = 0;
  int   bad   = 0;

  always #5 clk_i = ~clk_i;

  icache_refill_queue_if bus  ();
  icache_refill_queue_if bus3 ();

  icache_refill_queue u_dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .bus     (bus),
    .busy_o  (busy_o)
  );

  icache_refill_queue #(.MaxOutstanding(3)) u_dut3 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush3),
    .bus     (bus3),
    .busy_o  (busy3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [PLEN-1:0] pa, input logic nc,
                         input logic [IdWidth-1:0] tid);
    bus.req_valid_i = v;
    bus.req_paddr_i = pa;
    bus.req_nc_i    = nc;
    bus.req_tid_i   = tid;
  endtask

  task automatic set_beat(input logic v, input logic last, input logic okay);
    bus.rd_valid_i  = v;
    bus.rd_last_i   = last;
    bus.rd_exokay_i = okay;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 64'(bus.req_ready_o), 64'd1);
    check({tag, "_rdreq"}, 64'(bus.rd_req_o), 64'd0);
    check({tag, "_rtrnv"}, 64'(bus.rtrn_valid_o), 64'd0);
    check({tag, "_rtrne"}, 64'(bus.rtrn_err_o), 64'd0);
    check({tag, "_busy"},  64'(busy_o), 64'd0);
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; flush3 = 1'b0;
    set_req(1'b0, '0, 1'b0, '0);
    set_beat(1'b0, 1'b0, 1'b1);
    bus.rd_gnt_i = 1'b0;
    bus3.req_valid_i = 1'b0; bus3.req_paddr_i = '0; bus3.req_nc_i = 1'b0; bus3.req_tid_i = '0;
    bus3.rd_gnt_i = 1'b0; bus3.rd_valid_i = 1'b0; bus3.rd_last_i = 1'b0; bus3.rd_exokay_i = 1'b1;

    // Reset state.
    tick(); tick();
    check_reset_values("rst");
    rst_i = 1'b0;
    tick();

    // Cacheable line refill: 0x8000_1234 aligned to a 32-byte line is 0x8000_1220.
    set_req(1'b1, 56'h8000_1234, 1'b0, 4'd0);
    #1 check("a_ready", 64'(bus.req_ready_o), 64'd1);
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    check("a_rdreq", 64'(bus.rd_req_o), 64'd1);
    check("a_addr", bus.rd_addr_o, 64'h8000_1220);
    check("a_blen", 64'(bus.rd_blen_o), 64'd3);
    check("a_id", 64'(bus.rd_id_o), 64'd0);
    check("a_busy", 64'(busy_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("a_hold_req", 64'(bus.rd_req_o), 64'd1);
      check("a_hold_addr", bus.rd_addr_o, 64'h8000_1220);
    end
    bus.rd_gnt_i = 1'b1;
    tick();
    bus.rd_gnt_i = 1'b0;
    #1 check("a_req_after_gnt", 64'(bus.rd_req_o), 64'd0);
    for (int b = 0; b < 4; b++) begin
      set_beat(1'b1, b == 3, 1'b1);
      tick();
      if (b < 3) check("a_no_early_rtrn", 64'(bus.rtrn_valid_o), 64'd0);
    end
    set_beat(1'b0, 1'b0, 1'b1);
    #1;
    check("a_rtrn_valid", 64'(bus.rtrn_valid_o), 64'd1);
    check("a_rtrn_tid", 64'(bus.rtrn_tid_o), 64'd0);
    check("a_rtrn_nc", 64'(bus.rtrn_nc_o), 64'd0);
    check("a_rtrn_err", 64'(bus.rtrn_err_o), 64'd0);
    tick();
    check("a_pulse_end", 64'(bus.rtrn_valid_o), 64'd0);
    check("a_idle", 64'(busy_o), 64'd0);

    // Non-cacheable single beat with a bus error.
    set_req(1'b1, 56'h1000_0004, 1'b1, 4'd5);
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    check("b_addr", bus.rd_addr_o, 64'h1000_0004);
    check("b_blen", 64'(bus.rd_blen_o), 64'd0);
    check("b_id", 64'(bus.rd_id_o), 64'd5);
    bus.rd_gnt_i = 1'b1;
    tick();
    bus.rd_gnt_i = 1'b0;
    set_beat(1'b1, 1'b1, 1'b0);
    tick();
    set_beat(1'b0, 1'b0, 1'b1);
    #1;
    check("b_rtrn_valid", 64'(bus.rtrn_valid_o), 64'd1);
    check("b_rtrn_err", 64'(bus.rtrn_err_o), 64'd1);
    check("b_rtrn_nc", 64'(bus.rtrn_nc_o), 64'd1);
    check("b_rtrn_tid", 64'(bus.rtrn_tid_o), 64'd5);
    tick();

    // Fill: four accepted, fifth refused while grant is held low.
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, 56'h4000_0000 + 56'(i * 64), 1'b0, 4'(i + 1));
      #1 check("c_ready", 64'(bus.req_ready_o), (i < 4) ? 64'd1 : 64'd0);
      tick();
    end
    bus.req_valid_i = 1'b0;
    bus.rd_gnt_i = 1'b1;
    #1;
    check("c_iss1_req", 64'(bus.rd_req_o), 64'd1);
    check("c_iss1_id", 64'(bus.rd_id_o), 64'd1);
    tick();
    check("c_iss2_req", 64'(bus.rd_req_o), 64'd1);
    check("c_iss2_id", 64'(bus.rd_id_o), 64'd2);
    tick();
    check("c_limit_req", 64'(bus.rd_req_o), 64'd0);
    check("c_limit_ready", 64'(bus.req_ready_o), 64'd1);
    tick();
    check("c_limit_req2", 64'(bus.rd_req_o), 64'd0);
    set_beat(1'b1, 1'b1, 1'b1);
    tick();
    set_beat(1'b0, 1'b0, 1'b1);
    #1;
    check("c_rtrn1_valid", 64'(bus.rtrn_valid_o), 64'd1);
    check("c_rtrn1_tid", 64'(bus.rtrn_tid_o), 64'd1);
    check("c_rtrn1_err", 64'(bus.rtrn_err_o), 64'd0);
    check("c_iss3_req", 64'(bus.rd_req_o), 64'd1);
    check("c_iss3_id", 64'(bus.rd_id_o), 64'd3);
    tick();
    bus.rd_gnt_i = 1'b0;

    // Flush with two reads in flight (tid 2, 3) and tid 4 still queued.
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    check("d_busy_inflight", 64'(busy_o), 64'd1);
    check("d_req_empty", 64'(bus.rd_req_o), 64'd0);
    set_beat(1'b1, 1'b1, 1'b1);
    tick();
    check("d_kill1", 64'(bus.rtrn_valid_o), 64'd0);
    check("d_queue_empty", 64'(bus.rd_req_o), 64'd0);
    tick();
    set_beat(1'b0, 1'b0, 1'b1);
    #1;
    check("d_kill2", 64'(bus.rtrn_valid_o), 64'd0);
    check("d_busy_done", 64'(busy_o), 64'd0);
    check("d_ready", 64'(bus.req_ready_o), 64'd1);
    // Stray last with nothing outstanding.
    set_beat(1'b1, 1'b1, 1'b0);
    tick();
    set_beat(1'b0, 1'b0, 1'b1);
    #1;
    check("d_stray_rtrn", 64'(bus.rtrn_valid_o), 64'd0);
    check("d_stray_busy", 64'(busy_o), 64'd0);

    // Flush drops the queue and a same-cycle push, and masks rd_req_o at once.
    set_req(1'b1, 56'h6000_0000, 1'b0, 4'd6);
    tick();
    set_req(1'b1, 56'h6000_0040, 1'b0, 4'd7);
    #1 check("e_req_pre", 64'(bus.rd_req_o), 64'd1);
    flush_i = 1'b1;
    bus.rd_gnt_i = 1'b1;
    #1 check("e_req_flush", 64'(bus.rd_req_o), 64'd0);
    tick();
    flush_i = 1'b0;
    bus.rd_gnt_i = 1'b0;
    bus.req_valid_i = 1'b0;
    #1;
    check("e_req_post", 64'(bus.rd_req_o), 64'd0);
    check("e_busy_post", 64'(busy_o), 64'd0);

    // Reset between beat 2 and 3 of an erroring burst.
    set_req(1'b1, 56'h2000_0040, 1'b0, 4'd7);
    tick();
    bus.req_valid_i = 1'b0;
    bus.rd_gnt_i = 1'b1;
    tick();
    bus.rd_gnt_i = 1'b0;
    set_beat(1'b1, 1'b0, 1'b0);
    tick(); tick();
    set_beat(1'b0, 1'b0, 1'b1);
    rst_i = 1'b1;
    #1 check_reset_values("f_rst");
    tick();
    rst_i = 1'b0;
    set_beat(1'b1, 1'b0, 1'b1);
    tick();
    set_beat(1'b1, 1'b1, 1'b1);
    tick();
    set_beat(1'b0, 1'b0, 1'b1);
    #1;
    check("f_late_rtrn", 64'(bus.rtrn_valid_o), 64'd0);
    tick();
    check("f_late_rtrn2", 64'(bus.rtrn_valid_o), 64'd0);
    check("f_busy", 64'(busy_o), 64'd0);
    // Error state must not leak into the next transaction.
    set_req(1'b1, 56'h3000_0008, 1'b1, 4'd2);
    tick();
    bus.req_valid_i = 1'b0;
    bus.rd_gnt_i = 1'b1;
    tick();
    bus.rd_gnt_i = 1'b0;
    set_beat(1'b1, 1'b1, 1'b1);
    tick();
    set_beat(1'b0, 1'b0, 1'b1);
    #1;
    check("f_next_valid", 64'(bus.rtrn_valid_o), 64'd1);
    check("f_next_err", 64'(bus.rtrn_err_o), 64'd0);
    check("f_next_tid", 64'(bus.rtrn_tid_o), 64'd2);

    // Three-outstanding instance: grant and completion together at count 2.
    for (int i = 0; i < 4; i++) begin
      bus3.req_valid_i = 1'b1;
      bus3.req_paddr_i = 56'h5000_0000 + 56'(i * 64);
      bus3.req_tid_i   = 4'(i + 1);
      tick();
    end
    bus3.req_valid_i = 1'b0;
    bus3.rd_gnt_i = 1'b1;
    tick(); tick();
    bus3.rd_gnt_i = 1'b0;
    bus3.req_valid_i = 1'b1;
    bus3.req_paddr_i = 56'h5000_0100;
    bus3.req_tid_i   = 4'd5;
    tick();
    bus3.req_valid_i = 1'b0;
    #1;
    check("g_cnt2_req", 64'(bus3.rd_req_o), 64'd1);
    check("g_cnt2_id", 64'(bus3.rd_id_o), 64'd3);
    bus3.rd_gnt_i = 1'b1;
    bus3.rd_valid_i = 1'b1;
    bus3.rd_last_i = 1'b1;
    tick();
    bus3.rd_valid_i = 1'b0;
    bus3.rd_last_i = 1'b0;
    #1;
    check("g_rtrn_valid", 64'(bus3.rtrn_valid_o), 64'd1);
    check("g_rtrn_tid", 64'(bus3.rtrn_tid_o), 64'd1);
    check("g_still2_req", 64'(bus3.rd_req_o), 64'd1);
    check("g_still2_id", 64'(bus3.rd_id_o), 64'd4);
    tick();
    bus3.rd_gnt_i = 1'b0;
    #1;
    check("g_full_req", 64'(bus3.rd_req_o), 64'd0);
    check("g_full_busy", 64'(busy3), 64'd1);
    bus3.rd_valid_i = 1'b1;
    bus3.rd_last_i = 1'b1;
    tick();
    bus3.rd_valid_i = 1'b0;
    bus3.rd_last_i = 1'b0;
    #1;
    check("g_rtrn2_tid", 64'(bus3.rtrn_tid_o), 64'd2);
    check("g_reopen_req", 64'(bus3.rd_req_o), 64'd1);
    check("g_reopen_id", 64'(bus3.rd_id_o), 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
